// File: rtl/io_port_eeprom_bridge_if.sv
// rtl/io_port_eeprom_bridge_if.sv - CPU I/O page bus bundle for io_port_eeprom_bridge
interface io_port_eeprom_bridge_if;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       bus_rvalid;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_rdata, bus_rvalid
  );
endinterface

// File: rtl/io_port_eeprom_bridge.sv
// rtl/io_port_eeprom_bridge.sv - IO_DIR/IO_DATA port with open-drain EEPROM lines and save-dirty bus monitor
// Optional IO_GLITCH_FILTER_EN: synchronise and debounce the monitor's scl/sda copies.
module io_port_eeprom_bridge #(
  parameter logic [7:0] IO_BASE     = 8'h60,
  parameter int         FILTER_LEN  = 2,
  parameter int         DIRTY_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  io_port_eeprom_bridge_if.slave bus,
  output logic                   eeprom_clk,
  output logic                   eeprom_data,
  input  logic                   eeprom_data_in,
  input  logic                   ir_rx,
  output logic                   ir_tx,
  output logic                   rumble,
  output logic                   ir_disable,
  output logic                   save_dirty,
  input  logic                   save_clear,
  output logic [DIRTY_CNT_W-1:0] write_count
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CTRL, ST_ADDR_HI, ST_ADDR_LO, ST_DATA, ST_IGNORE
  } mon_state_e;

  logic [7:0] dir_q, dir_d, dat_q, dat_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;
  logic       hit_dir, hit_dat, sda_line;

  mon_state_e             state_q, state_d;
  logic [7:0]             sr_q, sr_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic                   dirty_q, dirty_d;
  logic [DIRTY_CNT_W-1:0] cnt_q, cnt_d;
  logic                   mon_scl, mon_sda;
  logic                   start_c, stop_c, rise_c, byte_done;

  // Undriven bits float high through the pull-up; rumble instead defaults off.
  assign ir_tx       = ~dir_q[0] | dat_q[0];
  assign eeprom_data = ~dir_q[2] | dat_q[2];
  assign eeprom_clk  = ~dir_q[3] | dat_q[3];
  assign ir_disable  = ~dir_q[5] | dat_q[5];
  assign rumble      = dir_q[4] & dat_q[4];
  assign sda_line    = eeprom_data & eeprom_data_in;

  assign hit_dir = (bus.bus_addr == IO_BASE);
  assign hit_dat = (bus.bus_addr == IO_BASE + 8'd1);

  assign bus.bus_rdata  = rdata_q;
  assign bus.bus_rvalid = rvalid_q;
  assign save_dirty     = dirty_q;
  assign write_count    = cnt_q;

  always_comb begin
    dir_d    = dir_q;
    dat_d    = dat_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (bus.bus_we && hit_dir) dir_d = bus.bus_wdata;
    if (bus.bus_we && hit_dat) dat_d = bus.bus_wdata;
    // Readback uses the pre-write register value, so same-cycle write+read returns old data.
    if (bus.bus_re && (hit_dir || hit_dat)) begin
      rvalid_d = 1'b1;
      rdata_d  = hit_dir ? dir_q : {dat_q[7:3], sda_line, ir_rx, dat_q[0]};
    end
  end

`ifdef IO_GLITCH_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]        sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    sync1_d = {eeprom_clk, sda_line};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    fcnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) filt_d = sync2_q;
      else fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign mon_scl = filt_q[1];
  assign mon_sda = filt_q[0];
`else
  assign mon_scl = eeprom_clk;
  assign mon_sda = sda_line;
`endif

  assign start_c = scl_prev_q & mon_scl & sda_prev_q & ~mon_sda;
  assign stop_c  = scl_prev_q & mon_scl & ~sda_prev_q & mon_sda;
  assign rise_c  = ~scl_prev_q & mon_scl;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bitcnt_d   = bitcnt_q;
    byte_done  = 1'b0;
    scl_prev_d = mon_scl;
    sda_prev_d = mon_sda;
    if (start_c) begin
      state_d  = ST_CTRL;
      bitcnt_d = 4'd0;
    end else if (stop_c) begin
      state_d  = ST_IDLE;
      bitcnt_d = 4'd0;
    end else if (rise_c && state_q != ST_IDLE && state_q != ST_IGNORE) begin
      // Ninth clock is the ACK slot: the sampled bit is not shifted in.
      if (bitcnt_q == 4'd8) begin
        bitcnt_d = 4'd0;
        case (state_q)
          ST_CTRL:    state_d = (sr_q == 8'hA0) ? ST_ADDR_HI : ST_IGNORE;
          ST_ADDR_HI: state_d = ST_ADDR_LO;
          ST_ADDR_LO: state_d = ST_DATA;
          ST_DATA:    byte_done = 1'b1;
          default:    state_d = state_q;
        endcase
      end else begin
        sr_d     = {sr_q[6:0], mon_sda};
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    dirty_d = dirty_q;
    cnt_d   = cnt_q;
    if (save_clear) begin
      dirty_d = 1'b0;
      cnt_d   = '0;
    end
    if (byte_done) begin
      dirty_d = 1'b1;
      if (save_clear) cnt_d = DIRTY_CNT_W'(1);
      else if (cnt_q != {DIRTY_CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q      <= 8'h00;
      dat_q      <= 8'h00;
      rdata_q    <= 8'h00;
      rvalid_q   <= 1'b0;
      state_q    <= ST_IDLE;
      sr_q       <= 8'h00;
      bitcnt_q   <= 4'd0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      dirty_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      dir_q      <= dir_d;
      dat_q      <= dat_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      state_q    <= state_d;
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      dirty_q    <= dirty_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_io_port_eeprom_bridge.sv
// tb/tb_io_port_eeprom_bridge.sv - directed bench for io_port_eeprom_bridge
module tb_io_port_eeprom_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        eeprom_clk, eeprom_data, ir_tx, rumble, ir_disable, save_dirty;
  logic        eeprom_data_in = 1'b1;
  logic        ir_rx = 1'b0;
  logic        save_clear = 1'b0;
  logic [15:0] write_count;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  rd;
  logic        rv;

  io_port_eeprom_bridge_if bus_if ();

  io_port_eeprom_bridge dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .eeprom_clk(eeprom_clk), .eeprom_data(eeprom_data), .eeprom_data_in(eeprom_data_in),
    .ir_rx(ir_rx), .ir_tx(ir_tx), .rumble(rumble), .ir_disable(ir_disable),
    .save_dirty(save_dirty), .save_clear(save_clear), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); bus_if.bus_addr = a; bus_if.bus_wdata = d; bus_if.bus_we = 1'b1;
    @(negedge clk); bus_if.bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic v);
    @(negedge clk); bus_if.bus_addr = a; bus_if.bus_re = 1'b1;
    @(negedge clk); bus_if.bus_re = 1'b0;
    d = bus_if.bus_rdata; v = bus_if.bus_rvalid;
  endtask

  task automatic set_lines(input logic scl, input logic sda);
    bus_write(8'h61, {4'b0000, scl, sda, 2'b00});
  endtask

  task automatic bb_setup();
    bus_write(8'h61, 8'h0C);
    bus_write(8'h60, 8'h0C);
  endtask

  task automatic send_bit(input logic b);
    set_lines(1'b0, b); set_lines(1'b1, b); set_lines(1'b0, b);
  endtask

  task automatic send_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v);
    send_bit(1'b1);
  endtask

  task automatic i2c_start();
    set_lines(1'b1, 1'b1); set_lines(1'b1, 1'b0); set_lines(1'b0, 1'b0);
  endtask

  task automatic i2c_stop();
    set_lines(1'b0, 1'b0); set_lines(1'b1, 1'b0); set_lines(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    vectors++; if (bus_if.bus_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b want 0", bus_if.bus_rvalid); end
    vectors++; if (bus_if.bus_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata got %h want 00", bus_if.bus_rdata); end
    vectors++; if ({eeprom_clk, eeprom_data, ir_tx, ir_disable} !== 4'b1111) begin miscompares++; $display("FAIL reset_pins got %b want 1111", {eeprom_clk, eeprom_data, ir_tx, ir_disable}); end
    vectors++; if (rumble !== 1'b0) begin miscompares++; $display("FAIL reset_rumble got %b want 0", rumble); end
    vectors++; if ({save_dirty, write_count} !== 17'h0) begin miscompares++; $display("FAIL reset_save got %b/%0d want 0/0", save_dirty, write_count); end
    reset = 1'b0;
    ir_rx = 1'b1; eeprom_data_in = 1'b1;
    bus_read(8'h61, rd, rv);
    vectors++; if (rv !== 1'b1) begin miscompares++; $display("FAIL rd61_rvalid got %b want 1", rv); end
    vectors++; if (rd !== 8'h06) begin miscompares++; $display("FAIL rd61_a got %h want 06", rd); end
    @(negedge clk);
    vectors++; if (bus_if.bus_rvalid !== 1'b0) begin miscompares++; $display("FAIL rvalid_pulse got %b want 0", bus_if.bus_rvalid); end
    ir_rx = 1'b1; eeprom_data_in = 1'b0;
    bus_read(8'h61, rd, rv);
    vectors++; if (rd !== 8'h02) begin miscompares++; $display("FAIL rd61_b got %h want 02", rd); end
    ir_rx = 1'b0; eeprom_data_in = 1'b1;
  endtask

  task automatic test_pins_readback();
    bus_write(8'h60, 8'h0C);
    bus_write(8'h61, 8'h04);
    vectors++; if ({eeprom_clk, eeprom_data} !== 2'b01) begin miscompares++; $display("FAIL pins_0c04 got %b want 01", {eeprom_clk, eeprom_data}); end
    eeprom_data_in = 1'b0;
    bus_read(8'h61, rd, rv);
    vectors++; if (rd !== 8'h00) begin miscompares++; $display("FAIL rd61_wired_and got %h want 00", rd); end
    eeprom_data_in = 1'b1;
    bus_read(8'h61, rd, rv);
    vectors++; if (rd !== 8'h04) begin miscompares++; $display("FAIL rd61_released got %h want 04", rd); end
    bus_read(8'h60, rd, rv);
    vectors++; if (rd !== 8'h0C) begin miscompares++; $display("FAIL rd60 got %h want 0C", rd); end
    bus_read(8'h62, rd, rv);
    vectors++; if ({rv, rd} !== {1'b0, 8'h0C}) begin miscompares++; $display("FAIL rd62_ignored got %b/%h want 0/0C", rv, rd); end
    @(negedge clk);
    bus_if.bus_addr = 8'h60; bus_if.bus_wdata = 8'h3C; bus_if.bus_we = 1'b1; bus_if.bus_re = 1'b1;
    @(negedge clk); bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0;
    vectors++; if ({bus_if.bus_rvalid, bus_if.bus_rdata} !== {1'b1, 8'h0C}) begin miscompares++; $display("FAIL rw_same got %b/%h want 1/0C", bus_if.bus_rvalid, bus_if.bus_rdata); end
    vectors++; if ({ir_disable, rumble, ir_tx} !== 3'b001) begin miscompares++; $display("FAIL pins_3c got %b want 001", {ir_disable, rumble, ir_tx}); end
    bus_write(8'h61, 8'h11);
    vectors++; if (rumble !== 1'b1) begin miscompares++; $display("FAIL rumble_on got %b want 1", rumble); end
  endtask

  task automatic test_write_txn();
    do_reset(); bb_setup();
    i2c_start(); send_byte(8'hA0); send_byte(8'h00); send_byte(8'h10);
    vectors++; if ({save_dirty, write_count} !== {1'b0, 16'd0}) begin miscompares++; $display("FAIL hdr_only got %b/%0d want 0/0", save_dirty, write_count); end
    send_byte(8'h55);
    vectors++; if (write_count !== 16'd1) begin miscompares++; $display("FAIL first_byte got %0d want 1", write_count); end
    send_byte(8'hAA); i2c_stop();
    vectors++; if ({save_dirty, write_count} !== {1'b1, 16'd2}) begin miscompares++; $display("FAIL two_bytes got %b/%0d want 1/2", save_dirty, write_count); end
    i2c_start(); send_byte(8'hA0); send_byte(8'h00); send_byte(8'h10);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); i2c_stop();
    vectors++; if (write_count !== 16'd2) begin miscompares++; $display("FAIL partial_byte got %0d want 2", write_count); end
    @(negedge clk); save_clear = 1'b1; @(negedge clk); save_clear = 1'b0;
    vectors++; if ({save_dirty, write_count} !== {1'b0, 16'd0}) begin miscompares++; $display("FAIL save_clear got %b/%0d want 0/0", save_dirty, write_count); end
  endtask

  task automatic test_read_txn();
    do_reset(); bb_setup();
    i2c_start(); send_byte(8'hA1); send_byte(8'hFF); send_byte(8'h12); i2c_stop();
    vectors++; if ({save_dirty, write_count} !== {1'b0, 16'd0}) begin miscompares++; $display("FAIL read_txn got %b/%0d want 0/0", save_dirty, write_count); end
  endtask

  task automatic test_clear_collision();
    do_reset(); bb_setup();
    i2c_start(); send_byte(8'hA0); send_byte(8'h00); send_byte(8'h10); send_byte(8'h55);
    send_bits(8'hAA);
    set_lines(1'b0, 1'b1); set_lines(1'b1, 1'b1);
    save_clear = 1'b1; @(negedge clk); save_clear = 1'b0;
    set_lines(1'b0, 1'b1);
    vectors++; if ({save_dirty, write_count} !== {1'b1, 16'd1}) begin miscompares++; $display("FAIL clear_vs_set got %b/%0d want 1/1", save_dirty, write_count); end
    send_byte(8'h33); i2c_stop();
    vectors++; if (write_count !== 16'd2) begin miscompares++; $display("FAIL after_collision got %0d want 2", write_count); end
  endtask

  task automatic test_reset_mid_txn();
    do_reset(); bb_setup();
    i2c_start(); send_byte(8'hA0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    do_reset();
    vectors++; if (write_count !== 16'd0) begin miscompares++; $display("FAIL midreset_cnt got %0d want 0", write_count); end
    bus_read(8'h60, rd, rv);
    vectors++; if (rd !== 8'h00) begin miscompares++; $display("FAIL midreset_dir got %h want 00", rd); end
    bus_read(8'h61, rd, rv);
    vectors++; if (rd !== 8'h04) begin miscompares++; $display("FAIL midreset_dat got %h want 04", rd); end
    bb_setup();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h33); i2c_stop();
    vectors++; if ({save_dirty, write_count} !== {1'b0, 16'd0}) begin miscompares++; $display("FAIL midreset_idle got %b/%0d want 0/0", save_dirty, write_count); end
  endtask

  initial begin
    bus_if.bus_addr = 8'h00; bus_if.bus_wdata = 8'h00;
    bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0;
    test_reset();
    test_pins_readback();
    test_write_txn();
    test_read_txn();
    test_clear_collision();
    test_reset_mid_txn();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
